// File: rtl/alu_dispatch.sv
// alu_dispatch: issue sequencer between fetch and the ALU/register file.
// Accepts one MIPS word, decodes it to an ALU op, runs one EXEC cycle and
// writes the result back. Four cycles per instruction, no pipelining.
module alu_dispatch #(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   output logic [4:0]         rs_addr,
   output logic [4:0]         rt_addr,
   input  logic [D_WIDTH-1:0] rs_data,
   input  logic [D_WIDTH-1:0] rt_data,
   output logic [2:0]         alu_op,
   output logic [D_WIDTH-1:0] alu_a,
   output logic [D_WIDTH-1:0] alu_b,
   output logic               alu_en,
   input  logic [D_WIDTH-1:0] alu_result,
   output logic               wb_en,
   output logic [4:0]         wb_addr,
   output logic [D_WIDTH-1:0] wb_data,
   output logic               done,
   output logic               illegal
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DECODE = 2'd1;
   localparam logic [1:0] EXEC   = 2'd2;
   localparam logic [1:0] WB     = 2'd3;

   logic [1:0]         state;
   logic [31:0]        instr;
   logic [4:0]         dest;

   logic               dec_valid;
   logic [2:0]         dec_op;
   logic [D_WIDTH-1:0] dec_a;
   logic [D_WIDTH-1:0] dec_b;
   logic [4:0]         dec_dest;

   assign in_ready = (state == IDLE);
   assign rs_addr  = instr[25:21];
   assign rt_addr  = instr[20:16];

   // Decode the latched word into op, operands and destination register.
   always_comb begin
      dec_valid = 1'b0;
      dec_op    = 3'd0;
      dec_a     = rs_data;
      dec_b     = rt_data;
      dec_dest  = instr[15:11];
      if (instr[31:26] == 6'h00) begin
         case (instr[5:0])
            6'h20: begin dec_valid = 1'b1; dec_op = 3'd0; end
            6'h22: begin dec_valid = 1'b1; dec_op = 3'd1; end
            6'h18: begin dec_valid = 1'b1; dec_op = 3'd2; end
            6'h1A: begin dec_valid = 1'b1; dec_op = 3'd3; end
            6'h00: begin
               dec_valid = 1'b1;
               dec_op    = 3'd4;
               dec_a     = rt_data;
               dec_b     = {{(D_WIDTH-5){1'b0}}, instr[10:6]};
            end
            6'h02: begin
               dec_valid = 1'b1;
               dec_op    = 3'd5;
               dec_a     = rt_data;
               dec_b     = {{(D_WIDTH-5){1'b0}}, instr[10:6]};
            end
            default: dec_valid = 1'b0;
         endcase
      end else if (instr[31:26] == 6'h08) begin
         // addi: immediate sign-extended, result goes to rt
         dec_valid = 1'b1;
         dec_op    = 3'd0;
         dec_b     = {{(D_WIDTH-16){instr[15]}}, instr[15:0]};
         dec_dest  = instr[20:16];
      end
   end

   // Sequencer state and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         instr   <= '0;
         dest    <= '0;
         alu_op  <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_en  <= 1'b0;
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         wb_en   <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  instr <= in_instr;
                  state <= DECODE;
               end
            end
            DECODE: begin
               if (dec_valid) begin
                  alu_en <= 1'b1;
                  alu_op <= dec_op;
                  alu_a  <= dec_a;
                  alu_b  <= dec_b;
                  dest   <= dec_dest;
                  state  <= EXEC;
               end else begin
                  illegal <= 1'b1;
                  state   <= IDLE;
               end
            end
            EXEC: begin
               alu_en  <= 1'b0;
               alu_op  <= '0;
               alu_a   <= '0;
               alu_b   <= '0;
               // wb_data doubles as the captured result register
               wb_data <= alu_result;
               wb_addr <= dest;
               wb_en   <= (dest != 5'd0);
               done    <= 1'b1;
               state   <= WB;
            end
            WB: begin
               wb_addr <= '0;
               wb_data <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: register file and ALU are modelled here; expected
// EXEC and write-back values are queued at accept and compared on output.
module tb_alu_dispatch;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [2:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_en;
   logic [31:0] alu_result;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        done;
   logic        illegal;

   alu_dispatch #(.D_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_en     (alu_en),
      .alu_result (alu_result),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .done       (done),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] regs [32];
   assign rs_data = regs[rs_addr];
   assign rt_data = regs[rt_addr];

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a * b;
         3'd3:    return (b == 0) ? 32'd0 : a / b;
         3'd4:    return a << b[4:0];
         3'd5:    return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction
   assign alu_result = alu_f(alu_op, alu_a, alu_b);

   typedef struct {
      logic        ill;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        wben;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   int   last_acc = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare whatever the DUT presents this cycle against the queue head.
   task automatic mon();
      exp_t e;
      if (alu_en) begin
         if (q.size() == 0) chk("exec_unexpected", 1, 0);
         else begin
            chk("exec_legal", q[0].ill, 0);
            chk("alu_op", alu_op, q[0].op);
            chk("alu_a", alu_a, q[0].a);
            chk("alu_b", alu_b, q[0].b);
         end
      end else begin
         chk("alu_idle_zero", (alu_op == 0 && alu_a == 0 && alu_b == 0), 1);
      end
      if (wb_en) chk("wb_en_without_done", done, 1);
      if (done) begin
         if (q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            chk("done_legal", e.ill, 0);
            chk("wb_en", wb_en, e.wben);
            chk("wb_addr", wb_addr, e.waddr);
            chk("wb_data", wb_data, e.wdata);
            chk("done_latency", cycle - e.acc, 3);
         end
      end
      if (illegal) begin
         if (q.size() == 0) chk("illegal_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            chk("illegal_expected", e.ill, 1);
            chk("illegal_in_ready", in_ready, 1);
            chk("illegal_quiet", alu_en | wb_en | done, 0);
            chk("illegal_latency", cycle - e.acc, 2);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cycle++;
      mon();
   endtask

   task automatic issue(input logic [31:0] ins, input logic ill, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic wben,
                        input logic [4:0] waddr, input logic [31:0] wdata, input bit hold);
      exp_t e;
      bit   acc;
      int   c0;
      in_valid = 1'b1;
      in_instr = ins;
      acc = 1'b0;
      c0 = cycle;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = in_ready;
         c0  = cycle;
         cyc();
      end
      chk("accept", acc, 1);
      if (acc) begin
         e.ill = ill; e.op = op; e.a = a; e.b = b;
         e.wben = wben; e.waddr = waddr; e.wdata = wdata; e.acc = c0;
         q.push_back(e);
      end
      last_acc = c0;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {alu_en, wb_en, done, illegal, alu_op, wb_addr}, 0);
      chk(tag, {alu_a, alu_b}, 0);
      chk(tag, wb_data, 0);
   endtask

   int acc1;

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_instr = 32'd0;
      #1;
      chk_all_zero("reset_outputs");
      chk("reset_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc();
      chk("idle_in_ready", in_ready, 1);

      // add $3,$1,$2 and add $0 (write suppressed, done still pulses)
      regs[1] = 32'd5; regs[2] = 32'd7;
      issue(32'h00221820, 0, 3'd0, 32'd5, 32'd7, 1, 5'd3, 32'd12, 0);
      drain();
      issue(32'h00220020, 0, 3'd0, 32'd5, 32'd7, 0, 5'd0, 32'd12, 0);
      drain();

      // sub, mult, div
      regs[1] = 32'd20; regs[2] = 32'd4;
      issue(32'h00223022, 0, 3'd1, 32'd20, 32'd4, 1, 5'd6, 32'd16, 0);
      drain();
      issue(32'h00223818, 0, 3'd2, 32'd20, 32'd4, 1, 5'd7, 32'd80, 0);
      drain();
      issue(32'h0022401A, 0, 3'd3, 32'd20, 32'd4, 1, 5'd8, 32'd5, 0);
      drain();

      // addi $4,$1,-3
      regs[1] = 32'd10;
      issue(32'h2024FFFD, 0, 3'd0, 32'd10, 32'hFFFF_FFFD, 1, 5'd4, 32'd7, 0);
      drain();

      // sll / srl $5,$2,3
      regs[2] = 32'd7;
      issue(32'h000228C0, 0, 3'd4, 32'd7, 32'd3, 1, 5'd5, 32'd56, 0);
      drain();
      regs[2] = 32'd64;
      issue(32'h000228C2, 0, 3'd5, 32'd64, 32'd3, 1, 5'd5, 32'd8, 0);
      drain();

      // lw and an unsupported funct are rejected
      issue(32'h8C220000, 1, 3'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 0);
      drain();
      cyc();
      chk("after_illegal_in_ready", in_ready, 1);
      issue(32'h00221821, 1, 3'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 0);
      drain();

      // back-to-back with in_valid held high
      regs[1] = 32'd5; regs[2] = 32'd7;
      issue(32'h00221820, 0, 3'd0, 32'd5, 32'd7, 1, 5'd3, 32'd12, 1);
      acc1 = last_acc;
      issue(32'h00223022, 0, 3'd1, 32'd5, 32'd7, 1, 5'd6, 32'hFFFF_FFFE, 0);
      chk("accept_spacing", last_acc - acc1, 4);
      drain();

      // reset during EXEC aborts with no write-back
      issue(32'h00224820, 0, 3'd0, 32'd5, 32'd7, 1, 5'd9, 32'd12, 0);
      for (int i = 0; i < 10 && !alu_en; i++) cyc();
      chk("reached_exec", alu_en, 1);
      rst = 1'b1;
      #1;
      chk_all_zero("abort_outputs");
      q.delete();
      cyc();
      rst = 1'b0;
      cyc();
      chk("abort_in_ready", in_ready, 1);
      chk("abort_no_wb", wb_en | done, 0);
      repeat (4) cyc();

      // still functional after the abort
      issue(32'h00221820, 0, 3'd0, 32'd5, 32'd7, 1, 5'd3, 32'd12, 0);
      drain();

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue sequencer on the producer side of the ALU interface.
- Accepts one MIPS instruction word per transaction over a valid/ready handshake, then decodes it to the 3-bit ALU op_code.
- Reads both source registers through the register-file read ports and drives operands and enable to the ALU.
- Captures the ALU result and writes it back to the register file.
- Sits between the fetch stage and the ALU/register file in the 32-bit MIPS GPP.

Parameters:
- D_WIDTH, 32, datapath width; matches the ALU operand/result width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction word present on in_instr.
- in_ready  output  1  dispatcher can accept an instruction.
- in_instr  input  32  MIPS instruction word.
- rs_addr  output  5  register-file read address A; equals instr[25:21] of the latched instruction.
- rt_addr  output  5  register-file read address B; equals instr[20:16] of the latched instruction.
- rs_data  input  D_WIDTH  combinational read data for rs_addr.
- rt_data  input  D_WIDTH  combinational read data for rt_addr.
- alu_op  output  3  ALU op_code.
- alu_a  output  D_WIDTH  ALU operand1.
- alu_b  output  D_WIDTH  ALU operand2.
- alu_en  output  1  ALU enable.
- alu_result  input  D_WIDTH  ALU result; combinational from alu_op, alu_a and alu_b.
- wb_en  output  1  register-file write enable.
- wb_addr  output  5  write-back register index.
- wb_data  output  D_WIDTH  write-back data.
- done  output  1  one-cycle pulse; instruction retired.
- illegal  output  1  one-cycle pulse; instruction rejected.

Behaviour:
- Reset: all outputs and internal registers are 0, state is IDLE. Because the reset is asynchronous, it aborts any in-flight instruction with no write-back.
- All outputs are registered, except in_ready, rs_addr and rt_addr, which decode from the state and the latched instruction.
- FSM states: IDLE, DECODE, EXEC, WB.

IDLE:
- in_ready=1.
- When in_valid=1, latch in_instr and move to DECODE.

DECODE:
- in_ready=0.
- Register rs_data and rt_data.
- Decode the latched instruction:
  - opcode 0x00, funct 0x20 (add): op 0, a=rs, b=rt, dest rd.
  - opcode 0x00, funct 0x22 (sub): op 1, a=rs, b=rt, dest rd.
  - opcode 0x00, funct 0x18 (mult): op 2, a=rs, b=rt, dest rd.
  - opcode 0x00, funct 0x1A (div): op 3, a=rs, b=rt, dest rd.
  - opcode 0x00, funct 0x00 (sll): op 4, a=rt, b=zero-extended shamt[10:6], dest rd.
  - opcode 0x00, funct 0x02 (srl): op 5, a=rt, b=zero-extended shamt, dest rd.
  - opcode 0x08 (addi): op 0, a=rs, b=sign-extended imm[15:0], dest rt.
- Valid encoding: go to EXEC.
- Any other opcode/funct: illegal=1 for the next cycle, return to IDLE. No ALU enable, no write-back.

EXEC (exactly one cycle):
- alu_en=1, with alu_op, alu_a and alu_b held stable.
- At the end of the cycle, capture alu_result into the result register and go to WB.
- Outside EXEC, alu_en=0 and alu_op, alu_a and alu_b are driven to 0.

WB (one cycle):
- done=1, wb_addr=dest, wb_data=captured result.
- wb_en=1 unless dest==0; a write to $0 is suppressed while done still pulses.
- Go to IDLE.
- wb_en, done and illegal are 0 in every other cycle.

Timing:
- Latency: handshake edge to done high is 3 cycles.
- Throughput: one instruction per 4 cycles.
- in_valid held high while busy is ignored until the next IDLE cycle; no instruction is dropped or duplicated.

Width rules:
- Operands are passed unmodified.
- Sign extension replicates imm[15].
- No overflow detection; wrap-around is the ALU's concern.

Test Plan:
- r1=5, r2=7, issue 0x00221820 (add $3,$1,$2) -> EXEC alu_op=0, a=5, b=7; WB wb_en=1, wb_addr=3, wb_data=12, done pulse 3 cycles after accept.
- r1=10, issue 0x2024FFFD (addi $4,$1,-3) -> alu_b=0xFFFFFFFD; wb_addr=4, wb_data=7.
- r2=7, issue 0x000228C0 (sll $5,$2,3) -> alu_op=4, alu_a=7, alu_b=3; wb_addr=5, wb_data=56. Repeat with funct 0x02 -> alu_op=5.
- Issue 0x8C220000 (lw) -> illegal pulse 1 cycle, alu_en and wb_en never high, back in IDLE (in_ready=1) the cycle after.
- Issue 0x00220020 (add $0,$1,$2) -> done pulses, wb_en stays 0.
- Hold in_valid high with two back-to-back instructions -> in_ready low for 3 cycles between accepts, both retire in order. Assert rst during EXEC -> all outputs 0 immediately, no wb_en, in_ready=1 after release.
